change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Consumes the 4-bit change amount produced by the change calculator and pays it out one coin at a time to the coin-ejector mechanism.
- Uses greedy selection over three denominations (4, 2, 1 units), limited by per-denomination inventory counters.
- Reports completion, and reports any shortfall when inventory cannot cover the amount.
- Sits between the change calculator and the physical ejector.

Parameters:
- MAX_CHANGE, 12, largest legal change amount; larger values are treated as a wrapped/underpaid result and rejected.
- INV_W, 4, width of each inventory counter.
- INIT_COUNT, 8, value loaded into every inventory counter on reset and on refill.
- TIMEOUT_CYCLES, 255, cycles to wait for coin_ack (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- change_valid  in  1  change_amount is valid.
- change_amount  in  4  change to dispense, in units.
- change_ready  out  1  block is idle and can accept a request.
- coin_req  out  1  request the ejector to drop the coin given by coin_type.
- coin_type  out  2  00 none, 01 one-unit, 10 two-unit, 11 four-unit.
- coin_ack  in  1  ejector has dropped the requested coin.
- refill  in  1  reload all inventories to INIT_COUNT.
- done  out  1  one-cycle pulse at the end of each transaction.
- short  out  1  last transaction could not be fully paid.
- short_amount  out  4  undispensed remainder of the last transaction.
- empty  out  3  {four,two,one}-unit inventory is zero.

Behaviour:
- Reset (asynchronous, on reset high):
  - State goes to IDLE.
  - change_ready=1; coin_req=0, coin_type=00, done=0, short=0, short_amount=0.
  - All inventories = INIT_COUNT; empty=000.
- States: IDLE, SELECT, REQ, DONE.
- IDLE:
  - change_ready=1.
  - change_valid is sampled on the rising edge. On accept: remaining <= change_amount; short and short_amount clear; next state SELECT.
  - If change_amount > MAX_CHANGE: no coins are issued. Set short=1, short_amount=change_amount, next state DONE.
- SELECT (one cycle):
  - Pick the largest coin value v such that remaining >= v and its inventory > 0.
  - remaining==0: go to DONE.
  - Coin found: coin_type <= its code, go to REQ.
  - No coin found with remaining>0: short=1, short_amount=remaining, go to DONE.
- REQ:
  - coin_req=1 and coin_type are held stable until coin_ack=1 is sampled.
  - On ack: remaining -= v, that inventory decrements, coin_req drops, go to SELECT.
  - Minimum spacing is therefore two cycles per coin.
- DONE: done=1 for exactly one cycle, coin_type=00, then IDLE.
- coin_ack outside REQ is ignored.
- refill is honoured only in IDLE. In other states it is ignored, not queued.
- Inventory counters never underflow: a zero inventory is never selected.
- empty is a registered copy of each counter==0.
- change_valid in a non-IDLE state is ignored; change_ready=0 there.
- Latency for amount N:
  - Accept edge, then SELECT at +1, REQ at +2.
  - With immediate acks, done asserts 2*coins+2 cycles after accept.
  - N=0 gives done at +2.
- Reset mid-transaction aborts immediately. The remainder is lost and no done pulse is issued.

Optional Feature:
- Macro: CHANGE_DISPENSER_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles in REQ without coin_ack, clearing on entry to REQ.
  - When the count reaches TIMEOUT_CYCLES: drop coin_req, set short=1 and short_amount=remaining, set output jam=1, go to DONE. The inventory is not decremented.
  - jam is a 1-bit output, sticky until reset or refill.
- Not defined: no watchdog and no jam port; REQ waits indefinitely.

Decomposition:
- Package vend_pkg holds:
  - coin_type encoding constants COIN_NONE/COIN_1/COIN_2/COIN_4.
  - coin value constants.
  - the state enum for IDLE/SELECT/REQ/DONE.
  - the MAX_CHANGE default.
- One natural sub-module: coin_select.
  - Purely combinational greedy picker.
  - Inputs: remaining, the three inventory-nonzero flags.
  - Outputs: coin_type, coin value, found.
- Counters and FSM stay in change_dispenser.

Test Plan:
- Amount 7, full inventory, ack one cycle after each req -> coin sequence 11,10,01; done once; short=0; counts 7/7/7.
- Four-unit inventory drained to 0, amount 6 -> coins 10,10,10; empty[2]=1; short=0.
- Inventory one-unit=1, two-unit=0, four-unit=0, amount 3 -> one coin 01; then short=1, short_amount=2; done pulse.
- Amount 15 (>MAX_CHANGE) -> no coin_req; short=1, short_amount=15; done 2 cycles after accept.
- Reset asserted while in REQ after first coin of amount 7:
  - coin_req drops asynchronously, inventories return to 8, change_ready=1, no done pulse.
  - A refill request arriving while busy is ignored.
- With CHANGE_DISPENSER_TIMEOUT_EN and TIMEOUT_CYCLES=10, amount 4 with no ack -> coin_req drops after 10 cycles; jam=1, short_amount=4; four-unit count unchanged.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin encodings, coin values and dispenser state type
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_4    = 2'b11;

  localparam logic [3:0] VAL_1 = 4'd1;
  localparam logic [3:0] VAL_2 = 4'd2;
  localparam logic [3:0] VAL_4 = 4'd4;

  localparam int MAX_CHANGE_DEF = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    REQ    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/coin_select.sv
// rtl/coin_select.sv - greedy picker: largest stocked coin not exceeding the remainder
module coin_select
  import vend_pkg::*;
(
  input  logic [3:0] remaining,
  input  logic       has4,
  input  logic       has2,
  input  logic       has1,
  output logic [1:0] coin_type,
  output logic [3:0] value,
  output logic       found
);

  always_comb begin
    coin_type = COIN_NONE;
    value     = '0;
    found     = 1'b0;
    if (has4 && remaining >= VAL_4) begin
      coin_type = COIN_4;
      value     = VAL_4;
      found     = 1'b1;
    end else if (has2 && remaining >= VAL_2) begin
      coin_type = COIN_2;
      value     = VAL_2;
      found     = 1'b1;
    end else if (has1 && remaining >= VAL_1) begin
      coin_type = COIN_1;
      value     = VAL_1;
      found     = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out change one coin at a time from 4/2/1 inventories
// Optional REQ watchdog and jam output: CHANGE_DISPENSER_TIMEOUT_EN
module change_dispenser
  import vend_pkg::*;
#(
  parameter int MAX_CHANGE = MAX_CHANGE_DEF,
  parameter int INV_W      = 4,
  parameter int INIT_COUNT = 8
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       change_valid,
  input  logic [3:0] change_amount,
  output logic       change_ready,
  output logic       coin_req,
  output logic [1:0] coin_type,
  input  logic       coin_ack,
  input  logic       refill,
  output logic       done,
  output logic       short,
  output logic [3:0] short_amount,
  output logic [2:0] empty
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  ,
  output logic       jam
`endif
);

  localparam logic [3:0]       MAX_AMT = 4'(MAX_CHANGE);
  localparam logic [INV_W-1:0] INIT_V  = INV_W'(INIT_COUNT);

  state_t           state, state_nx;
  logic [3:0]       remaining, coin_val;
  logic [1:0]       coin_code;
  logic [INV_W-1:0] inv4, inv2, inv1;
  logic [INV_W-1:0] inv4_nx, inv2_nx, inv1_nx;
  logic [1:0]       sel_type;
  logic [3:0]       sel_val;
  logic             sel_found;
  logic             req_timeout;

  coin_select u_sel (
    .remaining (remaining),
    .has4      (inv4 != '0),
    .has2      (inv2 != '0),
    .has1      (inv1 != '0),
    .coin_type (sel_type),
    .value     (sel_val),
    .found     (sel_found)
  );

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wd;

  assign req_timeout = (state == REQ) && !coin_ack && (wd == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd  <= '0;
      jam <= 1'b0;
    end else begin
      if (state == SELECT)
        wd <= '0;
      else if (state == REQ && !coin_ack && !req_timeout)
        wd <= wd + 8'd1;
      if (state == IDLE && refill)
        jam <= 1'b0;
      else if (req_timeout)
        jam <= 1'b1;
    end
  end
`else
  assign req_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // coin_type is only driven while a request is outstanding
  always_comb begin
    state_nx     = state;
    change_ready = 1'b0;
    coin_req     = 1'b0;
    coin_type    = COIN_NONE;
    done         = 1'b0;
    case (state)
      IDLE: begin
        change_ready = 1'b1;
        if (change_valid) state_nx = SELECT;
      end
      SELECT: begin
        if (remaining == '0 || !sel_found) state_nx = DONE;
        else                               state_nx = REQ;
      end
      REQ: begin
        coin_req  = 1'b1;
        coin_type = coin_code;
        if (coin_ack)         state_nx = SELECT;
        else if (req_timeout) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    inv4_nx = inv4;
    inv2_nx = inv2;
    inv1_nx = inv1;
    if (state == IDLE && refill) begin
      inv4_nx = INIT_V;
      inv2_nx = INIT_V;
      inv1_nx = INIT_V;
    end else if (state == REQ && coin_ack) begin
      case (coin_code)
        COIN_4:  inv4_nx = inv4 - INV_W'(1);
        COIN_2:  inv2_nx = inv2 - INV_W'(1);
        COIN_1:  inv1_nx = inv1 - INV_W'(1);
        default: ;
      endcase
    end
  end

  // Over-range amounts are flagged at accept and then fall through SELECT with nothing left
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining    <= '0;
      coin_code    <= COIN_NONE;
      coin_val     <= '0;
      inv4         <= INIT_V;
      inv2         <= INIT_V;
      inv1         <= INIT_V;
      short        <= 1'b0;
      short_amount <= '0;
      empty        <= '0;
    end else begin
      inv4  <= inv4_nx;
      inv2  <= inv2_nx;
      inv1  <= inv1_nx;
      empty <= {inv4_nx == '0, inv2_nx == '0, inv1_nx == '0};
      case (state)
        IDLE: begin
          if (change_valid) begin
            if (change_amount > MAX_AMT) begin
              remaining    <= '0;
              short        <= 1'b1;
              short_amount <= change_amount;
            end else begin
              remaining    <= change_amount;
              short        <= 1'b0;
              short_amount <= '0;
            end
          end
        end
        SELECT: begin
          if (remaining != '0) begin
            if (sel_found) begin
              coin_code <= sel_type;
              coin_val  <= sel_val;
            end else begin
              short        <= 1'b1;
              short_amount <= remaining;
            end
          end
        end
        REQ: begin
          if (coin_ack) begin
            remaining <= remaining - coin_val;
          end else if (req_timeout) begin
            short        <= 1'b1;
            short_amount <= remaining;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
